// File: rtl/mem_arbiter.sv
// Two-master arbiter in front of a single SDRAM controller port.
// Serialises read/write transactions and returns ack/err/rdata to the owner.
module mem_arbiter #(
    parameter int unsigned AW  = 23,
    parameter int unsigned DW  = 16,
    parameter int unsigned TMO = 255,
    parameter bit          RR  = 1'b1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          m0_req,
    input  logic          m1_req,
    input  logic          m0_we,
    input  logic          m1_we,
    input  logic [AW-1:0] m0_addr,
    input  logic [AW-1:0] m1_addr,
    input  logic [DW-1:0] m0_wdata,
    input  logic [DW-1:0] m1_wdata,
    output logic          m0_ack,
    output logic          m1_ack,
    output logic          m0_err,
    output logic          m1_err,
    output logic [DW-1:0] m_rdata,
    output logic          s_read,
    output logic          s_write,
    output logic [AW-1:0] s_addr,
    output logic [DW-1:0] s_wdata,
    input  logic          s_busy,
    input  logic          s_cack,
    input  logic          s_ready,
    input  logic [DW-1:0] s_rdata,
    output logic          grant
);

    localparam int unsigned CW = (TMO < 1) ? 1 : $clog2(TMO + 1);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_ISSUE    = 2'd1,
        S_WAIT_RDY = 2'd2,
        S_DONE     = 2'd3
    } state_t;

    state_t        r_state;
    logic          r_we;
    logic [AW-1:0] r_addr;
    logic [DW-1:0] r_wdata;
    logic          r_rd_pend;
    logic          r_wr_pend;
    logic          r_grant;
    logic          r_last;
    logic [CW-1:0] r_cnt;
    logic          r_ack0;
    logic          r_ack1;
    logic          r_err0;
    logic          r_err1;
    logic [DW-1:0] r_rdata;

    logic          w_any_req;
    logic          w_pick;
    logic [CW-1:0] w_cnt_nxt;
    logic          w_timeout;

    // Single request wins outright; a tie goes to m0 (fixed) or the one not served last (RR).
    assign w_any_req = m0_req | m1_req;
    assign w_pick    = (m0_req & m1_req) ? (RR ? ~r_last : 1'b0) : m1_req;
    assign w_cnt_nxt = r_cnt + CW'(1);
    assign w_timeout = (w_cnt_nxt >= CW'(TMO));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_we      <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_rd_pend <= 1'b0;
            r_wr_pend <= 1'b0;
            r_grant   <= 1'b0;
            r_last    <= 1'b1;
            r_cnt     <= '0;
            r_ack0    <= 1'b0;
            r_ack1    <= 1'b0;
            r_err0    <= 1'b0;
            r_err1    <= 1'b0;
            r_rdata   <= '0;
        end else begin
            r_ack0 <= 1'b0;
            r_ack1 <= 1'b0;
            r_err0 <= 1'b0;
            r_err1 <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_any_req) begin
                        r_grant   <= w_pick;
                        r_we      <= w_pick ? m1_we : m0_we;
                        r_addr    <= w_pick ? m1_addr : m0_addr;
                        r_wdata   <= w_pick ? m1_wdata : m0_wdata;
                        r_rd_pend <= ~(w_pick ? m1_we : m0_we);
                        r_wr_pend <= w_pick ? m1_we : m0_we;
                        r_state   <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (s_cack) begin
                        r_rd_pend <= 1'b0;
                        r_wr_pend <= 1'b0;
                        r_cnt     <= '0;
                        if (r_we || s_ready) begin
                            // Write done, or read data arrived together with the accept.
                            if (!r_we) r_rdata <= s_rdata;
                            r_ack0  <= ~r_grant;
                            r_ack1  <= r_grant;
                            r_state <= S_DONE;
                        end else begin
                            r_state <= S_WAIT_RDY;
                        end
                    end
                end
                S_WAIT_RDY: begin
                    if (s_ready) begin
                        r_rdata <= s_rdata;
                        r_ack0  <= ~r_grant;
                        r_ack1  <= r_grant;
                        r_state <= S_DONE;
                    end else if (w_timeout) begin
                        r_rdata <= '1;
                        r_ack0  <= ~r_grant;
                        r_ack1  <= r_grant;
                        r_err0  <= ~r_grant;
                        r_err1  <= r_grant;
                        r_state <= S_DONE;
                    end else begin
                        r_cnt <= w_cnt_nxt;
                    end
                end
                S_DONE: begin
                    r_last  <= r_grant;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Strobes are masked by s_busy so a command is only presented when it can be taken.
    assign s_read  = r_rd_pend & ~s_busy;
    assign s_write = r_wr_pend & ~s_busy;
    assign s_addr  = r_addr;
    assign s_wdata = r_wdata;
    assign m_rdata = r_rdata;
    assign m0_ack  = r_ack0;
    assign m1_ack  = r_ack1;
    assign m0_err  = r_err0;
    assign m1_err  = r_err1;
    assign grant   = r_grant;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a round-robin instance and a fixed-priority
// instance share all inputs; expected values are hand-derived per scenario.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        m0_req, m1_req, m0_we, m1_we;
    logic [22:0] m0_addr, m1_addr;
    logic [15:0] m0_wdata, m1_wdata;
    logic        s_busy, s_cack, s_ready;
    logic [15:0] s_rdata;

    logic        a_m0_ack, a_m1_ack, a_m0_err, a_m1_err, a_s_read, a_s_write, a_grant;
    logic [15:0] a_rdata, a_s_wdata;
    logic [22:0] a_s_addr;
    logic        b_m0_ack, b_m1_ack, b_m0_err, b_m1_err, b_s_read, b_s_write, b_grant;
    logic [15:0] b_rdata, b_s_wdata;
    logic [22:0] b_s_addr;

    int vecs = 0;
    int errs = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.AW(23), .DW(16), .TMO(8), .RR(1'b1)) dut_rr (
        .clk(clk), .rst_n(rst_n),
        .m0_req(m0_req), .m1_req(m1_req), .m0_we(m0_we), .m1_we(m1_we),
        .m0_addr(m0_addr), .m1_addr(m1_addr), .m0_wdata(m0_wdata), .m1_wdata(m1_wdata),
        .m0_ack(a_m0_ack), .m1_ack(a_m1_ack), .m0_err(a_m0_err), .m1_err(a_m1_err),
        .m_rdata(a_rdata), .s_read(a_s_read), .s_write(a_s_write),
        .s_addr(a_s_addr), .s_wdata(a_s_wdata),
        .s_busy(s_busy), .s_cack(s_cack), .s_ready(s_ready), .s_rdata(s_rdata),
        .grant(a_grant)
    );

    mem_arbiter #(.AW(23), .DW(16), .TMO(8), .RR(1'b0)) dut_fp (
        .clk(clk), .rst_n(rst_n),
        .m0_req(m0_req), .m1_req(m1_req), .m0_we(m0_we), .m1_we(m1_we),
        .m0_addr(m0_addr), .m1_addr(m1_addr), .m0_wdata(m0_wdata), .m1_wdata(m1_wdata),
        .m0_ack(b_m0_ack), .m1_ack(b_m1_ack), .m0_err(b_m0_err), .m1_err(b_m1_err),
        .m_rdata(b_rdata), .s_read(b_s_read), .s_write(b_s_write),
        .s_addr(b_s_addr), .s_wdata(b_s_wdata),
        .s_busy(s_busy), .s_cack(s_cack), .s_ready(s_ready), .s_rdata(s_rdata),
        .grant(b_grant)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        m0_req = 1'b0; m1_req = 1'b0; m0_we = 1'b0; m1_we = 1'b0;
        m0_addr = '0; m1_addr = '0; m0_wdata = '0; m1_wdata = '0;
        s_busy = 1'b0; s_cack = 1'b0; s_ready = 1'b0; s_rdata = '0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        rst_n = 1'b0;
        #1;
        vecs++;
        if ({a_m0_ack, a_m1_ack, a_m0_err, a_m1_err, a_s_read, a_s_write, a_grant} !== 7'b0) begin
            errs++;
            $display("FAIL reset_ctl: got %b want 0000000",
                     {a_m0_ack, a_m1_ack, a_m0_err, a_m1_err, a_s_read, a_s_write, a_grant});
        end
        vecs++;
        if ({a_s_addr, a_s_wdata, a_rdata} !== 55'b0) begin
            errs++;
            $display("FAIL reset_data: addr %h wdata %h rdata %h want 0", a_s_addr, a_s_wdata, a_rdata);
        end
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_read();
        do_reset();
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 23'h000010;
        tick();
        vecs++;
        if (a_s_read !== 1'b1 || a_s_write !== 1'b0 || a_s_addr !== 23'h000010 || a_grant !== 1'b0) begin
            errs++;
            $display("FAIL read_issue: rd %b wr %b addr %h grant %b want 1 0 000010 0",
                     a_s_read, a_s_write, a_s_addr, a_grant);
        end
        tick();
        s_cack = 1'b1;
        tick();
        s_cack = 1'b0;
        #1;
        vecs++;
        if (a_s_read !== 1'b0) begin
            errs++;
            $display("FAIL read_strobe_drop: got %b want 0", a_s_read);
        end
        tick();
        tick();
        s_ready = 1'b1; s_rdata = 16'hBEEF;
        tick();
        s_ready = 1'b0; m0_req = 1'b0;
        vecs++;
        if (a_m0_ack !== 1'b1 || a_m1_ack !== 1'b0 || a_m0_err !== 1'b0 || a_rdata !== 16'hBEEF) begin
            errs++;
            $display("FAIL read_ack: ack0 %b ack1 %b err %b rdata %h want 1 0 0 beef",
                     a_m0_ack, a_m1_ack, a_m0_err, a_rdata);
        end
        tick();
        vecs++;
        if (a_m0_ack !== 1'b0) begin
            errs++;
            $display("FAIL read_ack_pulse: got %b want 0", a_m0_ack);
        end
        s_ready = 1'b1; s_rdata = 16'h1111;
        tick();
        tick();
        s_ready = 1'b0;
        vecs++;
        if (a_rdata !== 16'hBEEF || a_m0_ack !== 1'b0 || a_m1_ack !== 1'b0) begin
            errs++;
            $display("FAIL stray_ready: rdata %h acks %b%b want beef 00", a_rdata, a_m0_ack, a_m1_ack);
        end
    endtask

    task automatic test_cack_ready();
        do_reset();
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 23'h000055;
        tick();
        s_cack = 1'b1; s_ready = 1'b1; s_rdata = 16'h1234;
        tick();
        s_cack = 1'b0; s_ready = 1'b0; m0_req = 1'b0;
        vecs++;
        if (a_m0_ack !== 1'b1 || a_rdata !== 16'h1234 || a_m0_err !== 1'b0) begin
            errs++;
            $display("FAIL cack_ready: ack %b rdata %h err %b want 1 1234 0", a_m0_ack, a_rdata, a_m0_err);
        end
        tick();
    endtask

    task automatic test_arbitration();
        int n;
        int fp_m0;
        int exp_g[3];
        exp_g = '{0, 1, 0};
        n = 0;
        fp_m0 = 0;
        do_reset();
        m0_req = 1'b1; m0_we = 1'b1; m0_addr = 23'h000100; m0_wdata = 16'hA0A0;
        m1_req = 1'b1; m1_we = 1'b1; m1_addr = 23'h000200; m1_wdata = 16'hB1B1;
        for (int c = 0; c < 30 && n < 3; c++) begin
            tick();
            s_cack = a_s_write | a_s_read;
            #1;
            vecs++;
            if (a_m0_ack && a_m1_ack) begin
                errs++;
                $display("FAIL rr_coincident_ack: cycle %0d both acks high", c);
            end
            vecs++;
            if (b_m1_ack !== 1'b0) begin
                errs++;
                $display("FAIL fp_m1_granted: cycle %0d m1_ack %b want 0", c, b_m1_ack);
            end
            if (b_m0_ack) fp_m0++;
            if (a_s_write) begin
                vecs++;
                if (a_s_wdata !== (a_grant ? 16'hB1B1 : 16'hA0A0)) begin
                    errs++;
                    $display("FAIL rr_wdata: grant %b wdata %h", a_grant, a_s_wdata);
                end
            end
            if (a_m0_ack || a_m1_ack) begin
                vecs++;
                if (int'(a_m1_ack) !== exp_g[n] || int'(a_grant) !== exp_g[n]) begin
                    errs++;
                    $display("FAIL rr_order: txn %0d ack1 %b grant %b want %0d", n, a_m1_ack, a_grant, exp_g[n]);
                end
                n++;
            end
        end
        vecs++;
        if (n !== 3) begin
            errs++;
            $display("FAIL rr_count: got %0d acks want 3", n);
        end
        vecs++;
        if (fp_m0 !== 3) begin
            errs++;
            $display("FAIL fp_m0_count: got %0d acks want 3", fp_m0);
        end
        m0_req = 1'b0; m1_req = 1'b0; s_cack = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_busy();
        do_reset();
        s_busy = 1'b1;
        m1_req = 1'b1; m1_we = 1'b1; m1_addr = 23'h003ABC; m1_wdata = 16'h5A5A;
        tick();
        m1_req = 1'b0; m1_addr = '0; m1_wdata = '0;
        #1;
        for (int i = 0; i < 10; i++) begin
            vecs++;
            if (a_s_write !== 1'b0) begin
                errs++;
                $display("FAIL busy_hold: cycle %0d s_write %b want 0", i, a_s_write);
            end
            tick();
        end
        s_busy = 1'b0;
        #1;
        vecs++;
        if (a_s_write !== 1'b1 || a_s_read !== 1'b0 || a_s_addr !== 23'h003ABC ||
            a_s_wdata !== 16'h5A5A || a_grant !== 1'b1) begin
            errs++;
            $display("FAIL busy_release: wr %b rd %b addr %h wdata %h grant %b want 1 0 003abc 5a5a 1",
                     a_s_write, a_s_read, a_s_addr, a_s_wdata, a_grant);
        end
        tick();
        vecs++;
        if (a_s_write !== 1'b1) begin
            errs++;
            $display("FAIL wr_held: got %b want 1", a_s_write);
        end
        s_cack = 1'b1;
        tick();
        s_cack = 1'b0;
        #1;
        vecs++;
        if (a_s_write !== 1'b0 || a_m1_ack !== 1'b1 || a_m0_ack !== 1'b0 ||
            a_m1_err !== 1'b0 || a_s_addr !== 23'h003ABC) begin
            errs++;
            $display("FAIL wr_done: wr %b ack1 %b ack0 %b err1 %b addr %h want 0 1 0 0 003abc",
                     a_s_write, a_m1_ack, a_m0_ack, a_m1_err, a_s_addr);
        end
        tick();
        vecs++;
        if (a_m1_ack !== 1'b0 || a_s_write !== 1'b0) begin
            errs++;
            $display("FAIL wr_idle: ack1 %b wr %b want 0 0", a_m1_ack, a_s_write);
        end
    endtask

    task automatic test_timeout();
        int k;
        k = 0;
        do_reset();
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 23'h000777;
        tick();
        s_cack = 1'b1;
        tick();
        s_cack = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (a_m0_ack || a_m1_ack) begin
                k = i;
                break;
            end
        end
        vecs++;
        if (k !== 8) begin
            errs++;
            $display("FAIL tmo_latency: got %0d cycles want 8", k);
        end
        vecs++;
        if (a_m0_ack !== 1'b1 || a_m0_err !== 1'b1 || a_rdata !== 16'hFFFF || a_m1_ack !== 1'b0) begin
            errs++;
            $display("FAIL tmo_err: ack0 %b err0 %b rdata %h ack1 %b want 1 1 ffff 0",
                     a_m0_ack, a_m0_err, a_rdata, a_m1_ack);
        end
        m0_req = 1'b0;
        tick();
        vecs++;
        if (a_m0_err !== 1'b0 || a_m0_ack !== 1'b0) begin
            errs++;
            $display("FAIL tmo_pulse: ack0 %b err0 %b want 0 0", a_m0_ack, a_m0_err);
        end
    endtask

    task automatic test_reset_abort();
        do_reset();
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 23'h000042;
        tick();
        s_cack = 1'b1;
        tick();
        s_cack = 1'b0;
        tick();
        rst_n = 1'b0;
        m0_req = 1'b0;
        #1;
        vecs++;
        if (a_s_addr !== 23'h0 || a_s_read !== 1'b0 || a_s_write !== 1'b0 ||
            a_grant !== 1'b0 || a_rdata !== 16'h0 || a_m0_ack !== 1'b0) begin
            errs++;
            $display("FAIL abort_outputs: addr %h rd %b wr %b grant %b rdata %h ack0 %b want all 0",
                     a_s_addr, a_s_read, a_s_write, a_grant, a_rdata, a_m0_ack);
        end
        s_ready = 1'b1; s_rdata = 16'hDEAD;
        tick();
        tick();
        vecs++;
        if (a_m0_ack !== 1'b0 || a_m1_ack !== 1'b0 || a_rdata !== 16'h0) begin
            errs++;
            $display("FAIL abort_no_ack: acks %b%b rdata %h want 00 0000", a_m0_ack, a_m1_ack, a_rdata);
        end
        s_ready = 1'b0;
        rst_n = 1'b1;
        m1_req = 1'b1; m1_we = 1'b0; m1_addr = 23'h000123;
        tick();
        vecs++;
        if (a_grant !== 1'b1 || a_s_read !== 1'b1 || a_s_addr !== 23'h000123) begin
            errs++;
            $display("FAIL post_rst_issue: grant %b rd %b addr %h want 1 1 000123", a_grant, a_s_read, a_s_addr);
        end
        s_cack = 1'b1;
        tick();
        s_cack = 1'b0;
        s_ready = 1'b1; s_rdata = 16'hC0DE;
        tick();
        s_ready = 1'b0; m1_req = 1'b0;
        vecs++;
        if (a_m1_ack !== 1'b1 || a_m0_ack !== 1'b0 || a_rdata !== 16'hC0DE || a_m1_err !== 1'b0) begin
            errs++;
            $display("FAIL post_rst_ack: ack1 %b ack0 %b rdata %h err1 %b want 1 0 c0de 0",
                     a_m1_ack, a_m0_ack, a_rdata, a_m1_err);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_read();
        test_cack_ready();
        test_arbitration();
        test_busy();
        test_timeout();
        test_reset_abort();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
